loadstore_unit: RTL and testbench

Memory-access stage directly downstream of the VLIW execution unit. It accepts one load or store per issue (address, size, sign-extend flag, destination register, store data) and runs it on a single-master req/ack word bus. Loaded data is aligned and extended, then delivered to the register-file write port. `busy` stalls issue until the access completes.

---
 rtl/loadstore_unit_if.sv | 33 +++
 rtl/loadstore_unit.sv | 215 +++++++++++++++++++++
 tb/tb_loadstore_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/loadstore_unit_if.sv
// loadstore_unit_if
//   Single-master req/ack word bus between the load/store unit and memory.
//   Parameter ADDR_W is the byte-address width; the word address is ADDR_W-2 bits.
//   Signals:
//     mem_req   : bus request, held until mem_ack
//     mem_we    : write strobe (store)
//     mem_addr  : word address
//     mem_sel   : byte-lane enables, bit n selects data[8n+7:8n]
//     mem_wdata : lane-positioned write data
//     mem_rdata : read data, valid with mem_ack
//     mem_ack   : single-cycle acknowledge
//   Modports: master (load/store unit), slave (memory).
interface loadstore_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_sel;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/loadstore_unit.sv
// loadstore_unit
//   Memory-access stage behind the execution unit. Accepts one load or store
//   per issue, runs it on the word bus, aligns/extends load data and delivers
//   it to the register-file write port.
//   Configuration macro: LSU_MISALIGNED_EN
//     defined   : word-crossing accesses are split into two bus cycles.
//     undefined : word-crossing accesses are rejected with misaligned_err.
//   Ports:
//     wb_clk_i, rst_n            : clock, asynchronous active-low reset
//     is_load, is_store          : issue strobes (mutually exclusive)
//     sign_extend                : sign-extend byte/half load results
//     loadstore_size             : 0 byte, 1 half, 2/3 word
//     loadstore_address          : byte address
//     loadstore_dest             : load destination register
//     store_data                 : right-aligned store value
//     busy                       : stall request to the execution stage
//     bus                        : word bus (master side)
//     wb_valid, wb_idx, wb_val   : load write-back pulse, register, value
//     misaligned_err             : rejected-access pulse
module loadstore_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              sign_extend,
  input  logic [1:0]        loadstore_size,
  input  logic [ADDR_W-1:0] loadstore_address,
  input  logic [4:0]        loadstore_dest,
  input  logic [31:0]       store_data,
  output logic              busy,
  loadstore_unit_if.master  bus,
  output logic              wb_valid,
  output logic [4:0]        wb_idx,
  output logic [31:0]       wb_val,
  output logic              misaligned_err
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
    logic [2:0] nb;
    case (size)
      2'd0:    nb = 3'd1;
      2'd1:    nb = 3'd2;
      default: nb = 3'd4;
    endcase
    return ({1'b0, off} + nb) > 3'd4;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] size,
                                              input logic sx);
    logic [31:0] r;
    case (size)
      2'd0:    r = {{24{sx & d[7]}}, d[7:0]};
      2'd1:    r = {{16{sx & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  state_t            state, state_nxt;
  logic              issue;
  logic              ld_p0, st_p0, sx_p0;
  logic [1:0]        size_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [4:0]        dest_p0;
  logic [31:0]       sdata_p0;
  logic [1:0]        off_p0;
  logic [ADDR_W-3:0] word_p0;
  logic [4:0]        sh_lo;
  logic              split_p0;
  logic [3:0]        sel0_w;
  logic [31:0]       wd0_w;
  logic [31:0]       rd_lo;
  logic              fin;
  logic [31:0]       res;

  assign issue    = is_load | is_store;
  assign off_p0   = addr_p0[1:0];
  assign word_p0  = addr_p0[ADDR_W-1:2];
  assign sh_lo    = {off_p0, 3'b000};
  assign split_p0 = crosses_word(size_p0, off_p0);
  // ACC0 lanes off..3 become result bytes 0..3-off.
  assign rd_lo    = bus.mem_rdata >> sh_lo;
  assign bus.mem_we = st_p0;

`ifdef LSU_MISALIGNED_EN
  logic [7:0]  sel_w;
  logic [63:0] wd_w;
  logic [5:0]  sh_hi;
  logic [31:0] rbuf_p1;
  logic [31:0] rd_hi;

  // Upper halves of the widened mask/data are exactly the lanes spilling into word+1.
  assign sel_w  = {4'b0000, size_mask(size_p0)} << off_p0;
  assign wd_w   = {32'h0, sdata_p0} << sh_lo;
  assign sel0_w = sel_w[3:0];
  assign wd0_w  = wd_w[31:0];
  assign sh_hi  = {3'd4 - {1'b0, off_p0}, 3'b000};
  assign rd_hi  = rbuf_p1 | (bus.mem_rdata << sh_hi);
  assign fin    = bus.mem_ack & (((state == ACC0) & ~split_p0) | (state == ACC1));
  assign res    = (state == ACC1) ? rd_hi : rd_lo;
  assign misaligned_err = 1'b0;
`else
  logic iss_split;

  assign iss_split = crosses_word(loadstore_size, loadstore_address[1:0]);
  assign sel0_w    = size_mask(size_p0) << off_p0;
  assign wd0_w     = sdata_p0 << sh_lo;
  assign fin       = bus.mem_ack & (state == ACC0);
  assign res       = rd_lo;
  // A rejected access reaches DONE with the crossing request still latched.
  assign misaligned_err = (state == DONE) & split_p0;
`endif

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_sel   = 4'b0000;
    bus.mem_wdata = 32'h0;
    case (state)
      IDLE: begin
        busy = issue;
        if (issue) begin
`ifdef LSU_MISALIGNED_EN
          state_nxt = ACC0;
`else
          state_nxt = iss_split ? DONE : ACC0;
`endif
        end
      end
      ACC0: begin
        busy          = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = word_p0;
        bus.mem_sel   = sel0_w;
        bus.mem_wdata = wd0_w;
        if (bus.mem_ack) begin
`ifdef LSU_MISALIGNED_EN
          state_nxt = split_p0 ? ACC1 : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef LSU_MISALIGNED_EN
      ACC1: begin
        busy          = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = word_p0 + WORD_ONE;
        bus.mem_sel   = sel_w[7:4];
        bus.mem_wdata = wd_w[63:32];
        if (bus.mem_ack) state_nxt = DONE;
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and write-back registers
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ld_p0    <= 1'b0;
      st_p0    <= 1'b0;
      wb_valid <= 1'b0;
      wb_idx   <= 5'd0;
      wb_val   <= 32'h0;
    end else begin
      state    <= state_nxt;
      wb_valid <= 1'b0;
      if ((state == IDLE) && issue) begin
        ld_p0 <= is_load;
        st_p0 <= is_store;
      end
      if (fin && ld_p0) begin
        wb_valid <= 1'b1;
        wb_idx   <= dest_p0;
        wb_val   <= extend_load(res, size_p0, sx_p0);
      end
    end
  end

  // Request latch (p0) and first-word read buffer (p1)
  always_ff @(posedge wb_clk_i) begin
    if ((state == IDLE) && issue) begin
      sx_p0    <= sign_extend;
      size_p0  <= loadstore_size;
      addr_p0  <= loadstore_address;
      dest_p0  <= loadstore_dest;
      sdata_p0 <= store_data;
    end
`ifdef LSU_MISALIGNED_EN
    if ((state == ACC0) && bus.mem_ack) rbuf_p1 <= rd_lo;
`endif
  end

endmodule

// File: tb/tb_loadstore_unit.sv
module tb_loadstore_unit;
  logic        clk;
  logic        rst_n;
  logic        is_load, is_store, sign_extend;
  logic [1:0]  loadstore_size;
  logic [31:0] loadstore_address;
  logic [4:0]  loadstore_dest;
  logic [31:0] store_data;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic [31:0] wb_val;
  logic        misaligned_err;

  int passed = 0;
  int total  = 0;

  loadstore_unit_if #(.ADDR_W(32)) bus ();

  loadstore_unit #(.ADDR_W(32)) dut (
    .wb_clk_i          (clk),
    .rst_n             (rst_n),
    .is_load           (is_load),
    .is_store          (is_store),
    .sign_extend       (sign_extend),
    .loadstore_size    (loadstore_size),
    .loadstore_address (loadstore_address),
    .loadstore_dest    (loadstore_dest),
    .store_data        (store_data),
    .busy              (busy),
    .bus               (bus),
    .wb_valid          (wb_valid),
    .wb_idx            (wb_idx),
    .wb_val            (wb_val),
    .misaligned_err    (misaligned_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one issue cycle; returns 2 time units into cycle T+1 with strobes low.
  task automatic issue(input logic ld, input logic [31:0] a, input logic [1:0] sz,
                       input logic sx, input logic [4:0] d, input logic [31:0] sd);
    is_load = ld; is_store = ~ld; sign_extend = sx;
    loadstore_size = sz; loadstore_address = a; loadstore_dest = d; store_data = sd;
    #1;
    chk("busy_on_issue", busy, 1'b1);
    tick();
    is_load = 1'b0; is_store = 1'b0;
    #1;
  endtask

  // Check one request cycle, acknowledge it with rdata, and step to the next cycle.
  task automatic bus_cycle(input string tag, input logic [29:0] ea, input logic [3:0] es,
                           input logic ewe, input logic chk_wd, input logic [31:0] ewd,
                           input logic [31:0] rdata);
    chk({tag, "_req"}, bus.mem_req, 1'b1);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_addr"}, bus.mem_addr, ea);
    chk({tag, "_sel"}, bus.mem_sel, es);
    chk({tag, "_we"}, bus.mem_we, ewe);
    if (chk_wd) chk({tag, "_wdata"}, bus.mem_wdata, ewd);
    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    #1;
  endtask

  task automatic wb_chk(input string tag, input logic ev, input logic [4:0] ei,
                        input logic [31:0] evl);
    chk({tag, "_wb_valid"}, wb_valid, ev);
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_req_done"}, bus.mem_req, 1'b0);
    if (ev) begin
      chk({tag, "_wb_idx"}, wb_idx, ei);
      chk({tag, "_wb_val"}, wb_val, evl);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    is_load = 1'b0; is_store = 1'b0; sign_extend = 1'b0;
    loadstore_size = 2'd0; loadstore_address = 32'h0; loadstore_dest = 5'd0;
    store_data = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_addr", bus.mem_addr, 30'h0);
    chk("rst_sel", bus.mem_sel, 4'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_idx", wb_idx, 5'd0);
    chk("rst_wb_val", wb_val, 32'h0);
    chk("rst_mis", misaligned_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Aligned word load
    issue(1'b1, 32'h100, 2'd2, 1'b0, 5'd5, 32'h0);
    bus_cycle("lw", 30'h40, 4'b1111, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF);
    wb_chk("lw", 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk("lw_pulse_end", wb_valid, 1'b0);
    chk("lw_val_hold", wb_val, 32'hDEADBEEF);

    // Byte loads from the top lane, signed and unsigned
    issue(1'b1, 32'h103, 2'd0, 1'b1, 5'd6, 32'h0);
    bus_cycle("lb_s", 30'h40, 4'b1000, 1'b0, 1'b0, 32'h0, 32'h80123456);
    wb_chk("lb_s", 1'b1, 5'd6, 32'hFFFFFF80);
    tick();
    issue(1'b1, 32'h103, 2'd0, 1'b0, 5'd7, 32'h0);
    bus_cycle("lb_u", 30'h40, 4'b1000, 1'b0, 1'b0, 32'h0, 32'h80123456);
    wb_chk("lb_u", 1'b1, 5'd7, 32'h00000080);
    tick();

    // Signed half load from the upper half
    issue(1'b1, 32'h102, 2'd1, 1'b1, 5'd8, 32'h0);
    bus_cycle("lh_s", 30'h40, 4'b1100, 1'b0, 1'b0, 32'h0, 32'h80017777);
    wb_chk("lh_s", 1'b1, 5'd8, 32'hFFFF8001);
    tick();

    // Half store to the upper half: no write-back, previous result held
    issue(1'b0, 32'h202, 2'd1, 1'b0, 5'd0, 32'h1234ABCD);
    bus_cycle("sh", 30'h80, 4'b1100, 1'b1, 1'b1, 32'hABCD0000, 32'h0);
    wb_chk("sh", 1'b0, 5'd0, 32'h0);
    chk("sh_val_hold", wb_val, 32'hFFFF8001);
    tick();

    // Byte store to lane 1
    issue(1'b0, 32'h001, 2'd0, 1'b0, 5'd0, 32'h00000055);
    bus_cycle("sb", 30'h0, 4'b0010, 1'b1, 1'b1, 32'h00005500, 32'h0);
    wb_chk("sb", 1'b0, 5'd0, 32'h0);
    tick();

`ifdef LSU_MISALIGNED_EN
    // Word load crossing words 0x3F/0x40
    issue(1'b1, 32'h0FE, 2'd2, 1'b0, 5'd9, 32'h0);
    bus_cycle("lw_split0", 30'h3F, 4'b1100, 1'b0, 1'b0, 32'h0, 32'hAABB0000);
    chk("lw_split0_wb", wb_valid, 1'b0);
    bus_cycle("lw_split1", 30'h40, 4'b0011, 1'b0, 1'b0, 32'h0, 32'h00001122);
    wb_chk("lw_split", 1'b1, 5'd9, 32'h1122AABB);
    chk("lw_split_mis", misaligned_err, 1'b0);
    tick();

    // Word store crossing words
    issue(1'b0, 32'h0FE, 2'd2, 1'b0, 5'd0, 32'h11223344);
    bus_cycle("sw_split0", 30'h3F, 4'b1100, 1'b1, 1'b1, 32'h33440000, 32'h0);
    bus_cycle("sw_split1", 30'h40, 4'b0011, 1'b1, 1'b1, 32'h00001122, 32'h0);
    wb_chk("sw_split", 1'b0, 5'd0, 32'h0);
    tick();

    // Half store at the top byte address wraps the second word to 0
    issue(1'b0, 32'hFFFFFFFF, 2'd1, 1'b0, 5'd0, 32'h0000BEEF);
    bus_cycle("sh_wrap0", 30'h3FFFFFFF, 4'b1000, 1'b1, 1'b1, 32'hEF000000, 32'h0);
    bus_cycle("sh_wrap1", 30'h0, 4'b0001, 1'b1, 1'b1, 32'h000000BE, 32'h0);
    wb_chk("sh_wrap", 1'b0, 5'd0, 32'h0);
    tick();
`else
    // Word-crossing load is rejected without a bus request
    issue(1'b1, 32'h0FE, 2'd2, 1'b0, 5'd9, 32'h0);
    chk("mis_req", bus.mem_req, 1'b0);
    chk("mis_busy", busy, 1'b0);
    chk("mis_err", misaligned_err, 1'b1);
    chk("mis_wb", wb_valid, 1'b0);
    tick();
    chk("mis_err_end", misaligned_err, 1'b0);
    chk("mis_val_hold", wb_val, 32'hFFFF8001);
    chk("mis_req_after", bus.mem_req, 1'b0);
    tick();
`endif

    // Load with four wait cycles before the acknowledge
    issue(1'b1, 32'h010, 2'd2, 1'b0, 5'd10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("wait_req", bus.mem_req, 1'b1);
      chk("wait_busy", busy, 1'b1);
      chk("wait_addr", bus.mem_addr, 30'h4);
      chk("wait_sel", bus.mem_sel, 4'b1111);
      chk("wait_wb", wb_valid, 1'b0);
      tick();
    end
    bus_cycle("wait", 30'h4, 4'b1111, 1'b0, 1'b0, 32'h0, 32'h0BADF00D);
    wb_chk("wait", 1'b1, 5'd10, 32'h0BADF00D);
    tick();

    // Reset asserted while a load waits in its first request cycle
    issue(1'b1, 32'h300, 2'd2, 1'b0, 5'd11, 32'h0);
    chk("rst_mid_req_before", bus.mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", bus.mem_req, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_wb_valid", wb_valid, 1'b0);
    chk("rst_mid_wb_val", wb_val, 32'h0);
    chk("rst_mid_sel", bus.mem_sel, 4'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Store after reset runs normally
    issue(1'b0, 32'h204, 2'd2, 1'b0, 5'd0, 32'hCAFEF00D);
    bus_cycle("sw_post", 30'h81, 4'b1111, 1'b1, 1'b1, 32'hCAFEF00D, 32'h0);
    wb_chk("sw_post", 1'b0, 5'd0, 32'h0);
    tick();
    chk("sw_post_idle_req", bus.mem_req, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
